// File: rtl/bitstream_prefetch_fifo.sv
// bitstream_prefetch_fifo
//
// Prefetch buffer between a block-oriented byte source and the bitstream
// parser. A watermark-driven refill FSM raises src_req_o while the buffer
// is below LOW_WM and drops it once HIGH_WM is reached. Data is withheld
// from the parser until PRIME_LEVEL words are buffered or the source has
// signalled end-of-file, so short files still become readable.
//
// Storage is a 2^AW-word synchronous RAM feeding a two-register prefetch
// pipeline (RAM read register -> head register), which gives a
// first-word-fall-through read port that can pop one word per cycle.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   flush_i        synchronous clear, highest priority
//   src_req_o      level request to the source (registered)
//   src_data_i     source word
//   src_valid_i    source word valid (accepted even while src_req_o=0)
//   src_end_i      source has delivered its last word
//   rd_i           pop the head word
//   rd_data_o      head word
//   rd_valid_o     head word available and priming complete
//   level_o        words held, RAM plus prefetch registers
//   stream_over_o  end seen and buffer empty
//   overflow_o     sticky: word dropped because the buffer was full
//   underrun_o     sticky: pop requested while rd_valid_o was low
module bitstream_prefetch_fifo #(
    parameter int DW          = 8,
    parameter int AW          = 11,
    parameter int LOW_WM      = 1024,
    parameter int HIGH_WM     = 1536,
    parameter int PRIME_LEVEL = 1536
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    output logic          src_req_o,
    input  logic [DW-1:0] src_data_i,
    input  logic          src_valid_i,
    input  logic          src_end_i,
    input  logic          rd_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic [AW:0]   level_o,
    output logic          stream_over_o,
    output logic          overflow_o,
    output logic          underrun_o
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] LowLvl   = (AW+1)'(LOW_WM);
    localparam logic [AW:0] HighLvl  = (AW+1)'(HIGH_WM);
    localparam logic [AW:0] PrimeLvl = (AW+1)'(PRIME_LEVEL);
    localparam logic [AW:0] FullLvl  = (AW+1)'(DEPTH);

    if (!(LOW_WM > 0 && LOW_WM < HIGH_WM && HIGH_WM <= DEPTH && PRIME_LEVEL <= HIGH_WM))
    begin : g_bad_params
        $error("bitstream_prefetch_fifo: illegal watermark/prime parameters");
    end

    typedef enum logic [1:0] {IDLE, FILL, ENDED} state_e;

    state_e          state_q;
    logic            src_req_q;
    logic [AW:0]     level_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic            head_valid_q;
    logic [DW-1:0]   head_data_q;
    logic            mid_valid_q;
    logic [DW-1:0]   mid_data_q;
    logic            end_seen_q;
    logic            prime_q;
    logic            overflow_q;
    logic            underrun_q;

    logic [DW-1:0]   mem [DEPTH];

    logic            primed;
    logic            pop;
    logic            wr;
    logic            head_load;
    logic            ram_nonempty;
    logic            ram_rd;

    // Words still sitting in the RAM are the level minus whatever the two
    // prefetch registers hold; only those can be read out of the RAM.
    assign ram_nonempty = level_q > ((AW+1)'(head_valid_q) + (AW+1)'(mid_valid_q));

    // Priming is satisfied as soon as the level or end-of-file allows it,
    // so the gate opens in the same cycle the level first reaches PRIME_LEVEL.
    assign primed     = !prime_q || (level_q >= PrimeLvl) || end_seen_q;
    assign rd_valid_o = head_valid_q && primed;

    assign pop       = rd_i && rd_valid_o;
    // A pop frees a slot in the same cycle, so a write at full is accepted with it.
    assign wr        = src_valid_i && ((level_q != FullLvl) || pop);
    assign head_load = mid_valid_q && (!head_valid_q || pop);
    assign ram_rd    = ram_nonempty && (!mid_valid_q || head_load);

    // RAM array and its registered read port; no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr && !flush_i) begin
            mem[wr_ptr_q] <= src_data_i;
        end
        if (ram_rd && !flush_i) begin
            mid_data_q <= mem[rd_ptr_q];
        end
    end

    // Level, pointers, prefetch pipeline and the sticky/priming flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            mid_valid_q  <= 1'b0;
            end_seen_q   <= 1'b0;
            prime_q      <= 1'b1;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else if (flush_i) begin
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            mid_valid_q  <= 1'b0;
            end_seen_q   <= 1'b0;
            prime_q      <= 1'b1;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            level_q  <= level_q + (AW+1)'(wr) - (AW+1)'(pop);
            wr_ptr_q <= wr_ptr_q + AW'(wr);
            rd_ptr_q <= rd_ptr_q + AW'(ram_rd);

            if (head_load) begin
                head_valid_q <= 1'b1;
                head_data_q  <= mid_data_q;
            end else if (pop) begin
                head_valid_q <= 1'b0;
            end

            if (ram_rd) begin
                mid_valid_q <= 1'b1;
            end else if (head_load) begin
                mid_valid_q <= 1'b0;
            end

            if (src_end_i) begin
                end_seen_q <= 1'b1;
            end
            if ((level_q >= PrimeLvl) || end_seen_q) begin
                prime_q <= 1'b0;
            end
            if (src_valid_i && !wr) begin
                overflow_q <= 1'b1;
            end
            if (rd_i && !rd_valid_o) begin
                underrun_q <= 1'b1;
            end
        end
    end

    // Refill FSM: decisions use the level registered at the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_req_q <= 1'b0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            src_req_q <= 1'b0;
        end else if (src_end_i) begin
            state_q   <= ENDED;
            src_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((level_q < LowLvl) && !end_seen_q) begin
                        state_q   <= FILL;
                        src_req_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (level_q >= HighLvl) begin
                        state_q   <= IDLE;
                        src_req_q <= 1'b0;
                    end
                end
                ENDED: begin
                    state_q   <= ENDED;
                    src_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    src_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign src_req_o     = src_req_q;
    assign rd_data_o     = head_data_q;
    assign level_o       = level_q;
    assign stream_over_o = end_seen_q && (level_q == '0);
    assign overflow_o    = overflow_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_bitstream_prefetch_fifo.sv
// tb_bitstream_prefetch_fifo
//
// Directed bench for bitstream_prefetch_fifo with default parameters.
// A queue-based reference model tracks the buffered words, the watermark
// request, priming and the sticky flags; every cycle its predictions are
// compared with the DUT outputs. Hand-computed literal expectations at
// key points of each scenario pin the model itself.
module tb_bitstream_prefetch_fifo;

    localparam int DW          = 8;
    localparam int AW          = 11;
    localparam int LOW_WM      = 1024;
    localparam int HIGH_WM     = 1536;
    localparam int PRIME_LEVEL = 1536;
    localparam int DEPTH       = 2048;

    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_ENDED = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush = 1'b0;
    logic          srcValid = 1'b0;
    logic [DW-1:0] srcData = '0;
    logic          srcEnd = 1'b0;
    logic          rd = 1'b0;

    logic          srcReq;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic [AW:0]   level;
    logic          streamOver;
    logic          overflow;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    // Source word counter, pop-sequence tracking.
    int  nextWord = 0;
    bit  seqOn = 0;
    int  expSeq = 0;
    int  popCount = 0;

    always #5 clk = ~clk;

    bitstream_prefetch_fifo #(
        .DW(DW), .AW(AW), .LOW_WM(LOW_WM), .HIGH_WM(HIGH_WM), .PRIME_LEVEL(PRIME_LEVEL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .src_req_o    (srcReq),
        .src_data_i   (srcData),
        .src_valid_i  (srcValid),
        .src_end_i    (srcEnd),
        .rd_i         (rd),
        .rd_data_o    (rdData),
        .rd_valid_o   (rdValid),
        .level_o      (level),
        .stream_over_o(streamOver),
        .overflow_o   (overflow),
        .underrun_o   (underrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state: buffered words with the edge they were written at.
    logic [DW-1:0] mq[$];
    int            mw[$];
    int            edgeNo = 0;
    int            lastPop = 0;
    bit            mPrime = 1;
    bit            mEnd = 0;
    bit            mOvf = 0;
    bit            mUnr = 0;
    bit            mReq = 0;
    int            mState = S_IDLE;

    // A word is at the read port two edges after it was written, and never
    // before the edge that popped its predecessor.
    function automatic bit expValid();
        int ready;
        if (mq.size() == 0) return 1'b0;
        if (mPrime && mq.size() < PRIME_LEVEL && !mEnd) return 1'b0;
        ready = (mw[0] + 2 > lastPop) ? mw[0] + 2 : lastPop;
        return edgeNo >= ready;
    endfunction

    task automatic modelClear();
        mq.delete();
        mw.delete();
        lastPop = 0;
        mPrime  = 1;
        mEnd    = 0;
        mOvf    = 0;
        mUnr    = 0;
        mReq    = 0;
        mState  = S_IDLE;
    endtask

    // Model update at each active edge, using the inputs held during the cycle.
    always @(posedge clk or negedge rst_n) begin : modelStep
        int sz;
        bit v;
        bit doPop;
        bit wrOk;
        if (!rst_n) begin
            modelClear();
        end else if (flush) begin
            modelClear();
            edgeNo++;
        end else begin
            sz    = mq.size();
            v     = expValid();
            doPop = rd && v;
            if (rd && !v) mUnr = 1;
            wrOk  = srcValid && (sz < DEPTH || doPop);
            if (srcValid && !wrOk) mOvf = 1;
            if (srcEnd) begin
                mState = S_ENDED;
                mReq   = 0;
            end else if (mState == S_IDLE && sz < LOW_WM && !mEnd) begin
                mState = S_FILL;
                mReq   = 1;
            end else if (mState == S_FILL && sz >= HIGH_WM) begin
                mState = S_IDLE;
                mReq   = 0;
            end
            if (sz >= PRIME_LEVEL || mEnd) mPrime = 0;
            if (srcEnd) mEnd = 1;
            edgeNo++;
            if (doPop) begin
                void'(mq.pop_front());
                void'(mw.pop_front());
                lastPop = edgeNo;
            end
            if (wrOk) begin
                mq.push_back(srcData);
                mw.push_back(edgeNo);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin : compare
        bit v;
        v = expValid();
        checkOutput("level", level, mq.size());
        checkOutput("rd_valid", rdValid, v);
        checkOutput("src_req", srcReq, mReq);
        checkOutput("stream_over", streamOver, mEnd && mq.size() == 0);
        checkOutput("overflow", overflow, mOvf);
        checkOutput("underrun", underrun, mUnr);
        if (v) checkOutput("rd_data", rdData, mq[0]);
    end

    // Popped words must form an incrementing byte sequence.
    always @(negedge clk) begin
        if (seqOn && rd && rdValid) begin
            checkOutput("pop_seq", rdData, expSeq);
            expSeq = (expSeq + 1) & 8'hFF;
            popCount++;
        end
    end

    // One cycle of stimulus: wait for the edge, then set the inputs for the
    // next cycle. The source may follow src_req or be forced; the parser may
    // pop whenever rd_valid is high or be pulsed explicitly.
    task automatic applyStimulus(input bit followReq, input bit forceValid, input bit endIn,
                                 input bit popWhenValid, input bit rdPulse, input bit flushIn);
        @(posedge clk);
        #2;
        if (srcValid) nextWord++;
        srcValid = forceValid || (followReq && srcReq);
        srcData  = nextWord[DW-1:0];
        srcEnd   = endIn;
        flush    = flushIn;
        rd       = rdPulse || (popWhenValid && rdValid);
    endtask

    initial begin
        bit done;

        // Reset and reset values.
        rst_n = 1'b0;
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("reset_src_req", srcReq, 0);
        checkOutput("reset_rd_valid", rdValid, 0);
        checkOutput("reset_rd_data", rdData, 0);
        checkOutput("reset_level", level, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Priming from reset with the source following src_req.
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("req_cycle1", srcReq, 1);
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (rdValid) done = 1;
        end
        checkOutput("prime_timeout", done, 1);
        checkOutput("prime_level", level, 1536);
        checkOutput("prime_first_data", rdData, 8'h00);
        checkOutput("prime_req_still_high", srcReq, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("req_fall", srcReq, 0);
        checkOutput("req_fall_level", level, 1537);

        // Continuous popping down to the low watermark.
        seqOn = 1;
        expSeq = 0;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 0);
            @(negedge clk);
            checkOutput("no_bubble_a", rdValid, 1);
            if (srcReq) done = 1;
        end
        checkOutput("low_wm_timeout", done, 1);
        checkOutput("req_rise_level", level, 1022);

        // Refill up to the high watermark without popping.
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (!srcReq) done = 1;
        end
        checkOutput("high_wm_timeout", done, 1);
        checkOutput("refill_level", level, 1537);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 0);
            @(negedge clk);
            checkOutput("no_bubble_b", rdValid, 1);
        end
        seqOn = 0;

        // Flush mid-stream with a word offered in the flush cycle.
        nextWord = 'hEE;
        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextWord = 'h40;
        @(negedge clk);
        checkOutput("flush_level", level, 0);
        checkOutput("flush_rd_valid", rdValid, 0);
        checkOutput("flush_stream_over", streamOver, 0);

        // Short 100-word file terminated by src_end.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 1, (i == 99), 0, 0, 0);
            if (i == 0) begin
                @(negedge clk);
                checkOutput("flush_req_next", srcReq, 1);
            end
        end
        seqOn = 1;
        expSeq = 'h40;
        popCount = 0;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            @(negedge clk);
            if (level == 0) done = 1;
        end
        checkOutput("short_file_timeout", done, 1);
        seqOn = 0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("short_pop_count", popCount, 100);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("short_stream_over", streamOver, 1);
            checkOutput("short_rd_valid", rdValid, 0);
            checkOutput("short_req_low", srcReq, 0);
        end

        // Pop attempted while still priming.
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("prime_underrun", underrun, 1);
        checkOutput("prime_underrun_level", level, 5);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flush_clears_underrun", underrun, 0);

        // Fill to exactly full, pop-with-write at full, then overflow.
        nextWord = 0;
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("full_level", level, 2048);
        checkOutput("full_no_overflow", overflow, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("full_popwrite_level", level, 2048);
        checkOutput("full_popwrite_overflow", overflow, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("overflow_set", overflow, 1);
        checkOutput("overflow_level", level, 2048);

        // Read everything back; word 0 was popped, word 2048 (0x00) is last.
        seqOn = 1;
        expSeq = 1;
        popCount = 0;
        done = 0;
        for (int i = 0; i < 2300 && !done; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            @(negedge clk);
            if (level == 0) done = 1;
        end
        checkOutput("readout_timeout", done, 1);
        seqOn = 0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("readout_count", popCount, 2048);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("empty_underrun", underrun, 1);
        checkOutput("empty_underrun_level", level, 0);

        // Asynchronous reset in the middle of streaming.
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_req", srcReq, 0);
        checkOutput("async_rst_level", level, 0);
        checkOutput("async_rst_rd_valid", rdValid, 0);
        checkOutput("async_rst_rd_data", rdData, 0);
        checkOutput("async_rst_overflow", overflow, 0);
        checkOutput("async_rst_underrun", underrun, 0);
        srcValid = 1'b0;
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (5) applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
